utmi_line_arbiter: RTL and testbench

Half-duplex line scheduler for the UTMI core. Decides, bit-clock by bit-clock, whether the shared USB line belongs to the receive path or the transmit path. Enforces inter-packet turnaround and a bounded response window after transmits that expect a reply. Drives the enable for the receive state machine and the grant/output-enable for the transmit state machine; neither path touches the line without this block's permission.

---
 rtl/utmi_pkg.sv | 22 ++
 rtl/utmi_arb_timer.sv | 35 +++
 rtl/utmi_line_arbiter.sv | 146 ++++++++++++++
 tb/tb_utmi_line_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/utmi_pkg.sv
// Shared definitions for the UTMI line arbiter: state codes, timer width,
// default turnaround/response windows.
package utmi_pkg;

  localparam int unsigned CNT_W            = 10;
  localparam int unsigned STAT_W           = 8;
  localparam int unsigned TA_CYCLES_DEF    = 16;
  localparam int unsigned RESP_TIMEOUT_DEF = 128;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RX        = 3'd1;
  localparam logic [2:0] ST_RX_TA     = 3'd2;
  localparam logic [2:0] ST_TX        = 3'd3;
  localparam logic [2:0] ST_TX_TA     = 3'd4;
  localparam logic [2:0] ST_RESP_WAIT = 3'd5;

  // States in which the receive path is allowed to listen to the line.
  function automatic logic rx_owned(input logic [2:0] st);
    return (st == ST_RX) || (st == ST_RESP_WAIT);
  endfunction

endpackage

// File: rtl/utmi_arb_timer.sv
// Loadable down-counter with zero flag; shared by turnaround and response
// window timing in utmi_line_arbiter. Holds at zero.
module utmi_arb_timer
  import utmi_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/utmi_line_arbiter.sv
// Half-duplex USB line scheduler between receive and transmit paths.
// Optional timeout statistics counter enabled by `define UTMI_ARB_STATS_EN.
module utmi_line_arbiter
  import utmi_pkg::*;
#(
  parameter int unsigned TA_CYCLES    = TA_CYCLES_DEF,
  parameter int unsigned RESP_TIMEOUT = RESP_TIMEOUT_DEF
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       LINE_ACTIVE,
  input  logic       EOP_DET,
  input  logic       TX_REQ,
  input  logic       EXPECT_RESP,
  input  logic       TX_DONE,
  output logic       TX_GRANT,
  output logic       TX_OE,
  output logic       RX_EN,
  output logic       RX_ABORT,
  output logic       RX_TIMEOUT,
  output logic [2:0] STATE,
  output logic [7:0] TIMEOUT_CNT
);

  // Turnaround is measured from the end-of-packet sample, so the entry edge
  // already counts as one cycle; the response window starts at entry.
  localparam logic [CNT_W-1:0] TA_LOAD   = CNT_W'(TA_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESP_LOAD = CNT_W'(RESP_TIMEOUT);

  logic [2:0]       state_q, state_d;
  logic             expect_q, expect_d;
  logic             grant_q, oe_q, rx_en_q, abort_q, timeout_q;
  logic             abort_d, timeout_d;
  logic             tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_val;

  utmi_arb_timer u_timer (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    expect_d  = expect_q;
    abort_d   = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (LINE_ACTIVE) begin
          state_d = ST_RX;
        end else if (TX_REQ) begin
          state_d  = ST_TX;
          expect_d = EXPECT_RESP;
        end
      end
      ST_RX: begin
        if (EOP_DET) begin
          state_d = ST_RX_TA;
        end else if (!LINE_ACTIVE) begin
          state_d = ST_RX_TA;
          abort_d = 1'b1;
        end
      end
      ST_RX_TA: begin
        if (LINE_ACTIVE) begin
          state_d = ST_RX;
        end else if (tmr_zero) begin
          state_d = ST_IDLE;
        end
      end
      ST_TX: begin
        if (TX_DONE) begin
          state_d = ST_TX_TA;
        end
      end
      ST_TX_TA: begin
        if (tmr_zero) begin
          state_d = expect_q ? ST_RESP_WAIT : ST_IDLE;
        end
      end
      ST_RESP_WAIT: begin
        if (LINE_ACTIVE) begin
          state_d = ST_RX;
        end else if (tmr_zero) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tmr_load = (state_d != state_q) &&
               ((state_d == ST_RX_TA) || (state_d == ST_TX_TA) ||
                (state_d == ST_RESP_WAIT));
    tmr_val  = (state_d == ST_RESP_WAIT) ? RESP_LOAD : TA_LOAD;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      expect_q  <= 1'b0;
      grant_q   <= 1'b0;
      oe_q      <= 1'b0;
      rx_en_q   <= 1'b0;
      abort_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      expect_q  <= expect_d;
      grant_q   <= (state_d == ST_TX);
      oe_q      <= (state_d == ST_TX);
      rx_en_q   <= rx_owned(state_d);
      abort_q   <= abort_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef UTMI_ARB_STATS_EN
  logic [STAT_W-1:0] stat_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stat_q <= '0;
    end else if (timeout_d && (stat_q != '1)) begin
      stat_q <= stat_q + STAT_W'(1);
    end
  end

  assign TIMEOUT_CNT = stat_q;
`else
  assign TIMEOUT_CNT = '0;
`endif

  assign TX_GRANT   = grant_q;
  assign TX_OE      = oe_q;
  assign RX_EN      = rx_en_q;
  assign RX_ABORT   = abort_q;
  assign RX_TIMEOUT = timeout_q;
  assign STATE      = state_q;

endmodule

// File: tb/tb_utmi_line_arbiter.sv
// Randomized bench for utmi_line_arbiter against a deadline-based line model.
module tb_utmi_line_arbiter;

  localparam int TA = 16;
  localparam int RT = 128;
`ifdef UTMI_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int M_IDLE = 0, M_RX = 1, M_RX_TA = 2, M_TX = 3, M_TX_TA = 4, M_RESP = 5;

  logic       clk, rst_n;
  logic       la, eop, req, er, done;
  logic       grant, oe, rx_en, abort, tmo;
  logic [2:0] st;
  logic [7:0] tcnt;

  int n_chk  = 0;
  int n_fail = 0;

  // model: owner of the line plus absolute edge number of next timed event
  int  m_state = M_IDLE;
  int  m_dl    = 0;
  bit  m_exp   = 1'b0;
  int  m_tcnt  = 0;
  bit  m_abort = 1'b0;
  bit  m_to    = 1'b0;
  int  e       = 0;
  bit  quiet   = 1'b0;

  utmi_line_arbiter #(.TA_CYCLES(TA), .RESP_TIMEOUT(RT)) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .LINE_ACTIVE (la),
    .EOP_DET     (eop),
    .TX_REQ      (req),
    .EXPECT_RESP (er),
    .TX_DONE     (done),
    .TX_GRANT    (grant),
    .TX_OE       (oe),
    .RX_EN       (rx_en),
    .RX_ABORT    (abort),
    .RX_TIMEOUT  (tmo),
    .STATE       (st),
    .TIMEOUT_CNT (tcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got=%0d expected=%0d", tag, $time, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_exp   = 1'b0;
    m_tcnt  = 0;
    m_abort = 1'b0;
    m_to    = 1'b0;
  endtask

  task automatic drive();
    eop  = ($urandom % 10) == 0;
    done = ($urandom % 25) == 0;
    if (quiet) la = la ? (($urandom % 4) != 0) : (($urandom % 1500) == 0);
    else if (($urandom % 8) == 0) la = ~la;
    if (m_state == M_TX) req = 1'b0;
    else if (!req && (($urandom % 30) == 0)) begin
      req = 1'b1;
      er  = $urandom % 2;
    end
  endtask

  // Next-edge prediction: turnaround ends TA edges after entry, the response
  // window expires RT+1 edges after entry.
  task automatic predict();
    e++;
    m_abort = 1'b0;
    m_to    = 1'b0;
    case (m_state)
      M_IDLE:
        if (la) m_state = M_RX;
        else if (req) begin m_state = M_TX; m_exp = er; end
      M_RX:
        if (eop || !la) begin
          m_abort = !eop;
          m_state = M_RX_TA;
          m_dl    = e + TA;
        end
      M_RX_TA:
        if (la) m_state = M_RX;
        else if (e == m_dl) m_state = M_IDLE;
      M_TX:
        if (done) begin m_state = M_TX_TA; m_dl = e + TA; end
      M_TX_TA:
        if (e == m_dl) begin
          if (m_exp) begin m_state = M_RESP; m_dl = e + RT + 1; end
          else m_state = M_IDLE;
        end
      M_RESP:
        if (la) m_state = M_RX;
        else if (e == m_dl) begin
          m_state = M_IDLE;
          m_to    = 1'b1;
          if (STATS && m_tcnt < 255) m_tcnt++;
        end
      default: m_state = M_IDLE;
    endcase
  endtask

  task automatic compare();
    chk("state",   int'(st),    m_state);
    chk("grant",   int'(grant), int'(m_state == M_TX));
    chk("oe",      int'(oe),    int'(m_state == M_TX));
    chk("rx_en",   int'(rx_en), int'(m_state == M_RX || m_state == M_RESP));
    chk("abort",   int'(abort), int'(m_abort));
    chk("timeout", int'(tmo),   int'(m_to));
    chk("tcnt",    int'(tcnt),  m_tcnt);
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_oe",    int'(oe),    0);
    chk("rst_grant", int'(grant), 0);
    chk("rst_state", int'(st),    0);
    chk("rst_tcnt",  int'(tcnt),  0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    la = 1'b0; eop = 1'b0; req = 1'b0; er = 1'b0; done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state",   int'(st),    0);
    chk("reset_grant",   int'(grant), 0);
    chk("reset_oe",      int'(oe),    0);
    chk("reset_rx_en",   int'(rx_en), 0);
    chk("reset_abort",   int'(abort), 0);
    chk("reset_timeout", int'(tmo),   0);
    chk("reset_tcnt",    int'(tcnt),  0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 9000; i++) begin
      @(negedge clk);
      if ((i % 400) == 0) quiet = ($urandom % 3) != 0;
      if (m_state == M_TX && (($urandom % 60) == 0)) mid_reset();
      drive();
      predict();
      @(posedge clk);
      #1;
      compare();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
